// File: rtl/player_pkg.sv
// Shared encodings for the player control FSM.
// State values and per-function command indices.
package player_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam int N_CMD    = 5;
  localparam int CMD_STOP = 0;
  localparam int CMD_PLAY = 1;
  localparam int CMD_NEXT = 2;
  localparam int CMD_PREV = 3;
  localparam int CMD_MUTE = 4;

endpackage

// File: rtl/player_ctrl_fsm_if.sv
// Button/remote inputs and transport outputs of the player controller.
// master drives buttons, slave is the controller.
interface player_ctrl_fsm_if #(
  parameter int TRACK_W = 2
);
  logic play_loc, stop_loc, next_loc, prev_loc, mute_loc;
  logic play_rem, stop_rem, next_rem, prev_rem, mute_rem;
  logic track_end;
  logic repeat_en;
  logic play_out;
  logic stop_out;
  logic pause_out;
  logic [TRACK_W-1:0] track_sel;
  logic mute_out;

  modport master (
    output play_loc, stop_loc, next_loc, prev_loc, mute_loc,
    output play_rem, stop_rem, next_rem, prev_rem, mute_rem,
    output track_end, repeat_en,
    input  play_out, stop_out, pause_out, track_sel, mute_out
  );

  modport slave (
    input  play_loc, stop_loc, next_loc, prev_loc, mute_loc,
    input  play_rem, stop_rem, next_rem, prev_rem, mute_rem,
    input  track_end, repeat_en,
    output play_out, stop_out, pause_out, track_sel, mute_out
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-button 2-FF synchroniser, stable-level debouncer, rising-edge pulse.
// Level is accepted after DEBOUNCE_CYC consecutive differing cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 255,
  parameter int CNT_W        = 8
) (
  input  logic clk_placa,
  input  logic rst_n,
  input  logic raw_in,
  output logic pulse_out
);

  logic             s1, s2;
  logic             stable, stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_placa or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw_in;
      s2       <= s1;
      stable_d <= stable;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign pulse_out = stable & ~stable_d;

endmodule

// File: rtl/player_ctrl_fsm.sv
// STOP/PLAY/PAUSE transport FSM with track select and mute,
// merging debounced board buttons and synchronised remote buttons.
module player_ctrl_fsm
  import player_pkg::*;
#(
  parameter int N_TRACKS     = 4,
  parameter int TRACK_W      = 2,
  parameter int DEBOUNCE_CYC = 255,
  parameter int CNT_W        = 8
) (
  input logic               clk_placa,
  input logic               rst_n,
  player_ctrl_fsm_if.slave  bus
);

  localparam logic [TRACK_W-1:0] LAST = TRACK_W'(N_TRACKS - 1);

  logic [N_CMD-1:0] loc_raw, rem_raw;
  logic [N_CMD-1:0] loc_pulse, rem_pulse, cmd;
  logic [N_CMD-1:0] rem_s1, rem_s2, rem_s3;

  assign loc_raw[CMD_STOP] = bus.stop_loc;
  assign loc_raw[CMD_PLAY] = bus.play_loc;
  assign loc_raw[CMD_NEXT] = bus.next_loc;
  assign loc_raw[CMD_PREV] = bus.prev_loc;
  assign loc_raw[CMD_MUTE] = bus.mute_loc;

  assign rem_raw[CMD_STOP] = bus.stop_rem;
  assign rem_raw[CMD_PLAY] = bus.play_rem;
  assign rem_raw[CMD_NEXT] = bus.next_rem;
  assign rem_raw[CMD_PREV] = bus.prev_rem;
  assign rem_raw[CMD_MUTE] = bus.mute_rem;

  for (genvar i = 0; i < N_CMD; i++) begin : g_loc
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
    ) u_db (
      .clk_placa (clk_placa),
      .rst_n     (rst_n),
      .raw_in    (loc_raw[i]),
      .pulse_out (loc_pulse[i])
    );
  end

  // Remote buttons are clean, so synchronise and edge-detect only.
  always_ff @(posedge clk_placa or negedge rst_n) begin
    if (!rst_n) begin
      rem_s1 <= '0;
      rem_s2 <= '0;
      rem_s3 <= '0;
    end else begin
      rem_s1 <= rem_raw;
      rem_s2 <= rem_s1;
      rem_s3 <= rem_s2;
    end
  end

  assign rem_pulse = rem_s2 & ~rem_s3;
  assign cmd       = loc_pulse | rem_pulse;

  state_e             state, nxt_state;
  logic [TRACK_W-1:0] track, nxt_track, trk_inc, trk_dec;
  logic               mute, nxt_mute;
  logic               stop_q, play_q, pause_q;

  assign trk_inc = (track == LAST) ? '0 : track + TRACK_W'(1);
  assign trk_dec = (track == '0) ? LAST : track - TRACK_W'(1);

  always_comb begin
    nxt_state = state;
    nxt_track = track;
    nxt_mute  = mute ^ cmd[CMD_MUTE];
    case (state)
      ST_STOP, ST_PLAY, ST_PAUSE: begin
        priority case (1'b1)
          cmd[CMD_STOP]: nxt_state = ST_STOP;
          cmd[CMD_PLAY]:
            nxt_state = (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
          cmd[CMD_NEXT]: nxt_track = trk_inc;
          cmd[CMD_PREV]: nxt_track = trk_dec;
          (bus.track_end && state == ST_PLAY): begin
            nxt_track = trk_inc;
            if (track == LAST && !bus.repeat_en) nxt_state = ST_STOP;
          end
          default: ;
        endcase
      end
      default: nxt_state = ST_STOP;
    endcase
  end

  always_ff @(posedge clk_placa or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      track   <= '0;
      mute    <= 1'b0;
      stop_q  <= 1'b1;
      play_q  <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      track   <= nxt_track;
      mute    <= nxt_mute;
      stop_q  <= (nxt_state == ST_STOP);
      play_q  <= (nxt_state == ST_PLAY);
      pause_q <= (nxt_state == ST_PAUSE);
    end
  end

  assign bus.stop_out  = stop_q;
  assign bus.play_out  = play_q;
  assign bus.pause_out = pause_q;
  assign bus.track_sel = track;
  assign bus.mute_out  = mute;

endmodule

// File: tb/tb_player_ctrl_fsm.sv
// Self-checking bench: directed scenarios plus random stimulus
// compared every cycle against a behavioural transport model.
module tb_player_ctrl_fsm;
  import player_pkg::*;

  localparam int NT = 3;
  localparam int TW = 2;
  localparam int DB = 16;

  logic       clk_placa = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] loc_v = '0;
  logic [4:0] rem_v = '0;
  logic       te = 1'b0;
  logic       rep = 1'b0;

  int errors = 0;
  int checks = 0;

  player_ctrl_fsm_if #(.TRACK_W(TW)) bus ();

  assign bus.stop_loc  = loc_v[CMD_STOP];
  assign bus.play_loc  = loc_v[CMD_PLAY];
  assign bus.next_loc  = loc_v[CMD_NEXT];
  assign bus.prev_loc  = loc_v[CMD_PREV];
  assign bus.mute_loc  = loc_v[CMD_MUTE];
  assign bus.stop_rem  = rem_v[CMD_STOP];
  assign bus.play_rem  = rem_v[CMD_PLAY];
  assign bus.next_rem  = rem_v[CMD_NEXT];
  assign bus.prev_rem  = rem_v[CMD_PREV];
  assign bus.mute_rem  = rem_v[CMD_MUTE];
  assign bus.track_end = te;
  assign bus.repeat_en = rep;

  player_ctrl_fsm #(
    .N_TRACKS     (NT),
    .TRACK_W      (TW),
    .DEBOUNCE_CYC (DB),
    .CNT_W        (5)
  ) dut (
    .clk_placa (clk_placa),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_placa = ~clk_placa;

  // Behavioural model. mode: 0 stop, 1 play, 2 pause.
  int         m_mode, m_track;
  bit         m_mute;
  logic [4:0] rd1, rd2, rd3, ld1, ld2;
  logic [4:0] acc, acc_prev, m_cmd;
  int         run [5];

  always @(posedge clk_placa or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_track = 0; m_mute = 0;
      rd1 = '0; rd2 = '0; rd3 = '0; ld1 = '0; ld2 = '0;
      acc = '0; acc_prev = '0;
      for (int i = 0; i < 5; i++) run[i] = 0;
    end else begin
      // button seen 2 cycles late; local needs DB cycles of agreement
      m_cmd = (rd2 & ~rd3) | (acc & ~acc_prev);
      acc_prev = acc;
      for (int i = 0; i < 5; i++) begin
        if (ld2[i] != acc[i]) begin
          run[i]++;
          if (run[i] == DB) begin acc[i] = ld2[i]; run[i] = 0; end
        end else run[i] = 0;
      end
      ld2 = ld1; ld1 = loc_v;
      rd3 = rd2; rd2 = rd1; rd1 = rem_v;
      if (m_cmd[CMD_MUTE]) m_mute = !m_mute;
      if (m_cmd[CMD_STOP]) m_mode = 0;
      else if (m_cmd[CMD_PLAY]) m_mode = (m_mode == 1) ? 2 : 1;
      else if (m_cmd[CMD_NEXT]) m_track = (m_track + 1) % NT;
      else if (m_cmd[CMD_PREV]) m_track = (m_track + NT - 1) % NT;
      else if (te && m_mode == 1) begin
        if (m_track < NT - 1) m_track = m_track + 1;
        else begin
          m_track = 0;
          if (!rep) m_mode = 0;
        end
      end
    end
  end

  always @(negedge clk_placa) begin
    if (rst_n) begin
      logic [5:0] act, exp;
      act = {bus.stop_out, bus.play_out, bus.pause_out,
             bus.track_sel, bus.mute_out};
      exp = {m_mode == 0, m_mode == 1, m_mode == 2,
             TW'(m_track), m_mute};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t got %b want %b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_placa);
  endtask

  task automatic rem_press(input int idx);
    @(negedge clk_placa);
    rem_v[idx] = 1'b1;
    cyc(2);
    rem_v[idx] = 1'b0;
    cyc(4);
  endtask

  task automatic te_pulse();
    @(negedge clk_placa);
    te = 1'b1;
    @(negedge clk_placa);
    te = 1'b0;
    cyc(2);
  endtask

  task automatic chk_out(input string nm, input int st, input int pl,
                         input int pa, input int tr, input int mu);
    chk({nm, ".stop"}, int'(bus.stop_out), st);
    chk({nm, ".play"}, int'(bus.play_out), pl);
    chk({nm, ".pause"}, int'(bus.pause_out), pa);
    chk({nm, ".track"}, int'(bus.track_sel), tr);
    chk({nm, ".mute"}, int'(bus.mute_out), mu);
  endtask

  // Wait for play_out, return edge count, -1 if it never comes.
  task automatic wait_play(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_placa);
      @(negedge clk_placa);
      if (bus.play_out) begin lat = i; break; end
    end
  endtask

  int play_rises = 0;
  logic play_d = 1'b0;
  always @(negedge clk_placa) begin
    if (bus.play_out && !play_d) play_rises++;
    play_d = bus.play_out;
  end

  int lat;
  int rh [5];
  int lh [5];

  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(1000);
    chk_out("idle", 1, 0, 0, 0, 0);

    // bouncy local play, then held
    for (int i = 0; i < 10; i++) begin
      loc_v[CMD_PLAY] = ~loc_v[CMD_PLAY];
      cyc(3);
    end
    play_rises = 0;
    loc_v[CMD_PLAY] = 1'b1;
    wait_play(lat);
    chk_rng("debounce_lat", lat, 2 + DB, 2 + DB + 2);
    loc_v[CMD_PLAY] = 1'b0;
    cyc(40);
    chk("play_entries", play_rises, 1);
    chk_out("after_release", 0, 1, 0, 0, 0);

    rem_press(CMD_STOP);
    chk_out("stop", 1, 0, 0, 0, 0);
    rem_press(CMD_NEXT);
    chk("next1", int'(bus.track_sel), 1);
    rem_press(CMD_NEXT);
    chk("next2", int'(bus.track_sel), 2);
    rem_press(CMD_NEXT);
    chk("next_wrap", int'(bus.track_sel), 0);
    rem_press(CMD_PREV);
    chk("prev_wrap", int'(bus.track_sel), 2);

    rem_press(CMD_PLAY);
    chk_out("play_t2", 0, 1, 0, 2, 0);
    rep = 1'b0;
    te_pulse();
    chk_out("end_norep", 1, 0, 0, 0, 0);
    rem_press(CMD_NEXT);
    rem_press(CMD_NEXT);
    rem_press(CMD_PLAY);
    rep = 1'b1;
    te_pulse();
    chk_out("end_rep", 0, 1, 0, 0, 0);
    te_pulse();
    chk_out("end_mid", 0, 1, 0, 1, 0);
    rem_press(CMD_PLAY);
    te_pulse();
    chk_out("end_pause", 0, 0, 1, 1, 0);
    rep = 1'b0;

    rem_press(CMD_PLAY);
    @(negedge clk_placa);
    rem_v[CMD_STOP] = 1'b1;
    rem_v[CMD_PLAY] = 1'b1;
    cyc(2);
    rem_v = '0;
    cyc(4);
    chk_out("stop_wins", 1, 0, 0, 1, 0);
    rem_press(CMD_PLAY);
    rem_press(CMD_MUTE);
    chk_out("mute_on", 0, 1, 0, 1, 1);
    rem_press(CMD_PLAY);
    rem_press(CMD_MUTE);
    chk_out("mute_off", 0, 0, 1, 1, 0);

    // reset mid-debounce while paused
    loc_v[CMD_PLAY] = 1'b1;
    cyc(8);
    @(posedge clk_placa);
    #3 rst_n = 1'b0;
    #1 chk_out("async_rst", 1, 0, 0, 0, 0);
    cyc(2);
    rst_n = 1'b1;
    wait_play(lat);
    chk_rng("rst_debounce_lat", lat, 2 + DB, 2 + DB + 2);
    loc_v[CMD_PLAY] = 1'b0;
    cyc(25);

    for (int i = 0; i < 5; i++) begin rh[i] = 0; lh[i] = 0; end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_placa);
      for (int i = 0; i < 5; i++) begin
        if (rh[i] == 0) begin
          rem_v[i] = ($urandom_range(0, 3) == 0);
          rh[i] = $urandom_range(2, 8);
        end
        rh[i]--;
        if (lh[i] == 0) begin
          loc_v[i] = ~loc_v[i];
          lh[i] = ($urandom_range(0, 1) == 1) ?
                  $urandom_range(1, 6) : $urandom_range(18, 40);
        end
        lh[i]--;
      end
      te = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) rep = ~rep;
    end
    rem_v = '0;
    loc_v = '0;
    te = 1'b0;
    cyc(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
